bcd_serial_accumulator: RTL and testbench

//  Downstream stage of the serial Excess-3 -> BCD converter. Consumes the converter's

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_bit_deserializer.sv | 61 ++++++
 rtl/bcd_serial_accumulator.sv | 104 ++++++++++
 tb/tb_bcd_serial_accumulator.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD definitions for the serial BCD accumulator slice.
//   BCD_W        bits per BCD digit
//   BCD_MAX      largest legal BCD digit value
//   bcd_digit_t  one BCD digit
//   is_valid_bcd returns 1 when a 4-bit code is a legal decimal digit (0..9)
package bcd_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  function automatic logic is_valid_bcd(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_bit_deserializer.sv
// bcd_bit_deserializer: assembles 4 serial bits (LSB first) into one BCD digit.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   din, din_en   serial bit and its qualifier; a bit is taken on every
//                 posedge with din_en=1. There is no ready: the stage always
//                 accepts, and din_en=0 cycles hold all state.
//   clr           synchronous clear of the partial digit; wins over din_en
//   asm_digit     combinational digit being completed this cycle
//   asm_done      combinational strobe: the 4th bit is being sampled now
//   digit         registered last assembled digit
//   digit_valid   registered 1-cycle pulse, one clock after the 4th bit
//   bit_cnt_dbg   current bit position, for observation
module bcd_bit_deserializer
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_en,
  input  logic       clr,
  output bcd_digit_t asm_digit,
  output logic       asm_done,
  output bcd_digit_t digit,
  output logic       digit_valid,
  output logic [1:0] bit_cnt_dbg
);

  logic [1:0] bit_cnt;
  // Bits shift in at the MSB end, so after three bits shreg = {b2, b1, b0}.
  logic [2:0] shreg;

  always_comb begin
    asm_digit = {din, shreg};
    asm_done  = din_en && !clr && (bit_cnt == 2'd3);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      digit       <= '0;
      digit_valid <= 1'b0;
    end else if (clr) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      digit_valid <= 1'b0;
    end else begin
      digit_valid <= asm_done;
      if (din_en) begin
        shreg   <= {din, shreg[2:1]};
        bit_cnt <= bit_cnt + 2'd1;
      end
      if (asm_done) begin
        digit <= asm_digit;
      end
    end
  end

  assign bit_cnt_dbg = bit_cnt;

endmodule

// File: rtl/bcd_serial_accumulator.sv
// bcd_serial_accumulator: takes the serial BCD stream of the Excess-3 -> BCD
// converter, assembles digits, range-checks them and accumulates accepted
// digits both as packed BCD (newest digit in the low nibble) and as binary.
// Ports:
//   Clk, Rst     clock, asynchronous active-high reset
//   Din, Din_en  serial bit (LSB of digit first) and its valid qualifier
//   Clr          synchronous clear of partial digit, accumulators, sticky flags
//   Digit        last assembled digit
//   Digit_valid  1-cycle pulse, Digit updated
//   Digit_err    1-cycle pulse together with Digit_valid when Digit > 9
//   Value        packed BCD of accepted digits
//   Bin          binary equivalent of Value
//   Count        number of accepted digits, 0..NUM_DIGITS
//   Err          sticky: a digit > 9 was seen
//   Ovf          sticky: digit rejected because full, or Bin overflowed
module bcd_serial_accumulator
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14,
  localparam int CNT_W     = $clog2(NUM_DIGITS + 1)
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        Din,
  input  logic                        Din_en,
  input  logic                        Clr,
  output bcd_digit_t                  Digit,
  output logic                        Digit_valid,
  output logic                        Digit_err,
  output logic [BCD_W*NUM_DIGITS-1:0] Value,
  output logic [BIN_W-1:0]            Bin,
  output logic [CNT_W-1:0]            Count,
  output logic                        Err,
  output logic                        Ovf
);

  bcd_digit_t asm_digit;
  logic       asm_done;
  logic [1:0] bit_cnt_dbg;

  bcd_bit_deserializer u_deser (
    .clk         (Clk),
    .rst         (Rst),
    .din         (Din),
    .din_en      (Din_en),
    .clr         (Clr),
    .asm_digit   (asm_digit),
    .asm_done    (asm_done),
    .digit       (Digit),
    .digit_valid (Digit_valid),
    .bit_cnt_dbg (bit_cnt_dbg)
  );

  // Accumulators update on the same edge that registers Digit, so the new
  // Value/Bin are visible in the cycle Digit_valid is high.
  logic             asm_ok;
  logic             full;
  logic [BIN_W+3:0] bin_wide;
  logic             bin_ovf;

  always_comb begin
    asm_ok   = is_valid_bcd(asm_digit);
    full     = (Count == CNT_W'(NUM_DIGITS));
    // Bin*10 + d as (Bin<<3)+(Bin<<1)+d, with 4 guard bits for overflow.
    bin_wide = ({4'b0, Bin} << 3) + ({4'b0, Bin} << 1) + {{BIN_W{1'b0}}, asm_digit};
    bin_ovf  = |bin_wide[BIN_W+3:BIN_W];
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Digit_err <= 1'b0;
      Value     <= '0;
      Bin       <= '0;
      Count     <= '0;
      Err       <= 1'b0;
      Ovf       <= 1'b0;
    end else if (Clr) begin
      Digit_err <= 1'b0;
      Value     <= '0;
      Bin       <= '0;
      Count     <= '0;
      Err       <= 1'b0;
      Ovf       <= 1'b0;
    end else begin
      Digit_err <= asm_done && !asm_ok;
      if (asm_done) begin
        if (!asm_ok) begin
          Err <= 1'b1;
        end else if (full) begin
          Ovf <= 1'b1;
        end else begin
          Value <= {Value[BCD_W*NUM_DIGITS-BCD_W-1:0], asm_digit};
          Bin   <= bin_wide[BIN_W-1:0];
          Count <= Count + CNT_W'(1);
          if (bin_ovf) begin
            Ovf <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_serial_accumulator.sv
module tb_bcd_serial_accumulator;

  localparam int N     = 4;
  localparam int BIN_W = 14;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Din = 1'b0;
  logic        Din_en = 1'b0;
  logic        Clr = 1'b0;
  logic [3:0]  Digit;
  logic        Digit_valid;
  logic        Digit_err;
  logic [15:0] Value;
  logic [13:0] Bin;
  logic [2:0]  Count;
  logic        Err;
  logic        Ovf;

  bcd_serial_accumulator #(.NUM_DIGITS(N), .BIN_W(BIN_W)) dut (
    .Clk(Clk), .Rst(Rst), .Din(Din), .Din_en(Din_en), .Clr(Clr),
    .Digit(Digit), .Digit_valid(Digit_valid), .Digit_err(Digit_err),
    .Value(Value), .Bin(Bin), .Count(Count), .Err(Err), .Ovf(Ovf)
  );

  // clock
  always #5 Clk = ~Clk;

  // reference model: accepted decimal digits, oldest first
  logic [3:0] exp_q[$];
  int         m_digit;
  bit         m_err;
  bit         m_ovf;
  int         total = 0;
  int         bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_value();
    int v = 0;
    foreach (exp_q[i]) v = v * 16 + int'(exp_q[i]);
    return v;
  endfunction

  function automatic int model_bin();
    int v = 0;
    foreach (exp_q[i]) v = v * 10 + int'(exp_q[i]);
    return v % (1 << BIN_W);
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_err = 0;
    m_ovf = 0;
  endtask

  // a complete digit as the model sees it
  task automatic model_digit(input int d);
    m_digit = d;
    if (d > 9) m_err = 1;
    else if (exp_q.size() == N) m_ovf = 1;
    else begin
      exp_q.push_back(4'(d));
      // decimal value above the binary range also flags overflow
      if (model_bin() != (model_bin_unwrapped())) m_ovf = 1;
    end
  endtask

  function automatic int model_bin_unwrapped();
    int v = 0;
    foreach (exp_q[i]) v = v * 10 + int'(exp_q[i]);
    return v;
  endfunction

  task automatic check_accum(input string tag);
    check({tag, ".value"}, 32'(Value), 32'(model_value()));
    check({tag, ".bin"},   32'(Bin),   32'(model_bin()));
    check({tag, ".count"}, 32'(Count), 32'(exp_q.size()));
    check({tag, ".err"},   32'(Err),   32'(m_err));
    check({tag, ".ovf"},   32'(Ovf),   32'(m_ovf));
  endtask

  // driver: optional idle gap, then present one bit for one posedge
  task automatic send_bit(input logic b, input int max_gap);
    int gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
    repeat (gap) begin
      @(negedge Clk);
      Din_en = 1'b0;
      Din = 1'($urandom_range(1, 0));
    end
    @(negedge Clk);
    Din = b;
    Din_en = 1'b1;
  endtask

  task automatic send_digit(input string tag, input int d, input int max_gap);
    logic [3:0] v = 4'(d);
    for (int i = 0; i < 4; i++) send_bit(v[i], max_gap);
    @(negedge Clk);
    Din_en = 1'b0;
    model_digit(d);
    check({tag, ".valid"}, 32'(Digit_valid), 32'd1);
    check({tag, ".digit"}, 32'(Digit), 32'(m_digit));
    check({tag, ".derr"},  32'(Digit_err), 32'(d > 9));
    check_accum(tag);
    @(negedge Clk);
    check({tag, ".pulse"}, 32'(Digit_valid | Digit_err), 32'd0);
  endtask

  task automatic do_clr();
    @(negedge Clk);
    Clr = 1'b1;
    @(negedge Clk);
    Clr = 1'b0;
    model_clear();
  endtask

  initial begin
    model_clear();
    m_digit = 0;

    // 1. reset, reset mid-digit, then digit 3
    repeat (2) @(negedge Clk);
    check("rst.digit", 32'(Digit), 32'd0);
    check("rst.valid", 32'(Digit_valid), 32'd0);
    check_accum("rst");
    Rst = 1'b0;
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    @(negedge Clk);
    Din_en = 1'b0;
    Rst = 1'b1;
    #1;
    check("rst2.digit", 32'(Digit), 32'd0);
    check_accum("rst2");
    @(negedge Clk);
    Rst = 1'b0;
    send_digit("t1", 3, 0);

    // 2. digit 9 from clean state
    do_clr();
    check_accum("clr");
    send_digit("t2", 9, 0);

    // 3. fill to four digits, then a rejected fifth
    do_clr();
    for (int i = 1; i <= 4; i++) send_digit("t3", i, 1);
    check("t3.value1234", 32'(Value), 32'h1234);
    check("t3.bin1234",   32'(Bin),   32'd1234);
    send_digit("t3.full", 5, 1);
    check("t3.ovf", 32'(Ovf), 32'd1);

    // 4. illegal digit 10
    send_digit("t4", 10, 0);
    check("t4.err", 32'(Err), 32'd1);

    // 5. partial digit then Clr together with Din_en
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    @(negedge Clk);
    Din = 1'b1;
    Din_en = 1'b1;
    Clr = 1'b1;
    @(negedge Clk);
    Clr = 1'b0;
    Din_en = 1'b0;
    model_clear();
    check("t5.valid", 32'(Digit_valid), 32'd0);
    check_accum("t5.clr");
    send_digit("t5", 6, 0);
    check("t5.value", 32'(Value), 32'h0006);

    // 6. Excess-3 codes through the converter, random gaps
    do_clr();
    begin
      int xs3[3] = '{7, 12, 3};
      foreach (xs3[i]) send_digit("t6", xs3[i] - 3, 3);
    end
    check("t6.bin490", 32'(Bin), 32'd490);

    // back-to-back digits 7 then 8: Digit_valid only every 4th cycle
    do_clr();
    begin
      logic [7:0] bits = 8'h87;
      for (int k = 0; k < 8; k++) begin
        @(negedge Clk);
        check("b2b.valid", 32'(Digit_valid), 32'(k == 4));
        if (k == 4) check("b2b.digit7", 32'(Digit), 32'd7);
        if (k == 4) model_digit(7);
        Din = bits[k];
        Din_en = 1'b1;
      end
      @(negedge Clk);
      Din_en = 1'b0;
      model_digit(8);
      check("b2b.valid2", 32'(Digit_valid), 32'd1);
      check("b2b.digit8", 32'(Digit), 32'd8);
      check_accum("b2b");
    end

    // random digits, including illegal codes and overflow
    for (int r = 0; r < 3; r++) begin
      do_clr();
      for (int i = 0; i < 8; i++) send_digit("rnd", $urandom_range(15, 0), 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
